calc_seq: RTL and testbench
===========================

CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 Parameter MUL_LAT, default 2, is the fixed multiplier latency in clk cycles, with a legal range of 1..15.
REQ-002 Parameter TMO, default 255, is the maximum number of cycles to wait for ok_div or ok_dec, with a legal range of 1..255.
REQ-003 clk  input  1  is the single system clock; all logic SHALL be clocked on the rising edge.
REQ-004 rst_n  input  1  is the reset: synchronous and active-low.
REQ-005 ce  input  1  is the one-cycle-wide 1 ms tick.
REQ-006 A  input  16  is the binary dividend operand before scaling.
REQ-007 B  input  16  is the binary divisor operand.
REQ-008 ok_div  input  1  is the divider-done pulse.
REQ-009 ok_dec  input  1  is the binary-to-decimal converter done pulse.
REQ-010 st_div  output  1  is the one-cycle divider start pulse.
REQ-011 st_dec  output  1  is the one-cycle converter start pulse.
REQ-012 res_we  output  1  is the one-cycle result-valid strobe.
REQ-013 busy  output  1  is high in any state except IDLE and ERR.
REQ-014 err_div0  output  1  is the sticky divide-by-zero flag.
REQ-015 err_tmo  output  1  is the sticky handshake-timeout flag.
REQ-016 calc_cnt  output  8  counts completed calculations and wraps modulo 256.

Function
REQ-017 The FSM SHALL have exactly five states: IDLE, MUL_WAIT, DIV_RUN, DEC_RUN and ERR.
REQ-018 In IDLE, ce=1 together with an active trigger (see REQ-030 and REQ-031) SHALL capture A into Ar and B into Br.
REQ-019 On that same edge, the FSM SHALL go to ERR if B==0, and to MUL_WAIT otherwise.
REQ-020 MUL_WAIT SHALL last exactly MUL_LAT cycles.
REQ-021 st_div SHALL be high only in the first cycle of DIV_RUN: with ce sampled at edge 0, st_div is high in cycle MUL_LAT+1.
REQ-022 In DIV_RUN, ok_div SHALL be honoured only from the cycle after st_div; ok_div=1 SHALL move the FSM to DEC_RUN, with st_dec high in the first DEC_RUN cycle.
REQ-023 In DEC_RUN, ok_dec SHALL be honoured only from the cycle after st_dec; ok_dec=1 SHALL return the FSM to IDLE, with res_we high for one cycle, calc_cnt incremented and both error flags cleared.
REQ-024 A timeout counter SHALL clear on entry to DIV_RUN and on entry to DEC_RUN; if TMO cycles elapse without the awaited ok, the FSM SHALL go to ERR and set err_tmo.
REQ-025 If ok arrives in the same cycle as timeout expiry, ok SHALL win and no error is flagged.
REQ-026 Entering ERR because B==0 SHALL set err_div0 and SHALL NOT issue st_div or st_dec.
REQ-027 ERR SHALL return to IDLE on the next ce without starting a calculation; error flags SHALL remain set until the next res_we or reset.
REQ-028 ce, ok_div and ok_dec outside the states listed above SHALL be ignored, with no queuing.
REQ-029 calc_cnt SHALL wrap from 255 to 0.

Configuration
REQ-030 With CALC_SEQ_CHANGE_DET_EN defined, the trigger SHALL be true only when A!=Ar, B!=Br, or the internal flag "last result invalid" is set; that flag is set by reset or ERR and cleared by res_we.
REQ-031 Without CALC_SEQ_CHANGE_DET_EN, the trigger SHALL be constantly true, so every ce seen in IDLE starts a calculation.

Reset
REQ-032 rst_n=0 sampled on a rising clk edge SHALL force state IDLE and clear st_div, st_dec, res_we, busy, err_div0, err_tmo, calc_cnt, Ar, Br and the timeout counter.
REQ-033 Reset SHALL also set "last result invalid".
REQ-034 Reset asserted mid-operation SHALL abort the operation with no further start or result pulses.
REQ-035 Outputs SHALL be registered and hold their reset values until the first non-reset edge.

Verification
REQ-036 Nominal run: MUL_LAT=2, A=100, B=7, ce at cycle 0, ok_div at cycle 10, ok_dec at cycle 20 -> st_div at cycle 3, st_dec at cycle 11, res_we at cycle 21, calc_cnt=1, busy high in cycles 1..20.
REQ-037 Divide by zero: B=0 with ce -> err_div0=1, no st_div or st_dec; the next ce returns the FSM to IDLE, then B=5 with ce runs to res_we and clears err_div0.
REQ-038 Timeout: TMO=255, ok_div never asserted -> err_tmo=1 exactly 255 cycles after st_div, no st_dec; ok_div at exactly cycle 255 -> no error, st_dec issued.
REQ-039 Change detect (macro defined): after one completed run, three ce ticks with A and B unchanged -> no st_div; changing A to 101 before the next ce -> a new run starts.
REQ-040 Change detect (macro undefined): three ce ticks with A and B unchanged -> three complete runs, calc_cnt=3.
REQ-041 Reset mid-DIV_RUN: rst_n=0 for one cycle -> IDLE, all outputs 0; a late ok_div afterwards causes no st_dec.

Source files
------------

// File: rtl/calc_seq.sv
// Calculation sequencer: multiply wait, divider and decimal-converter handshakes, timeout and error flags.
// Optional change detection (only start when operands differ or last result invalid): CALC_SEQ_CHANGE_DET_EN.
module calc_seq #(
    parameter int unsigned MUL_LAT = 2,    // 1..15
    parameter int unsigned TMO     = 255   // 1..255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        ok_div,
    input  logic        ok_dec,
    output logic        st_div,
    output logic        st_dec,
    output logic        res_we,
    output logic        busy,
    output logic        err_div0,
    output logic        err_tmo,
    output logic [7:0]  calc_cnt
);

    localparam int unsigned OP_W  = 16;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TMR_W = 8;

    localparam logic [TMR_W-1:0] MUL_LAST = TMR_W'(MUL_LAT - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_WAIT = 3'd1,
        S_DIV_RUN  = 3'd2,
        S_DEC_RUN  = 3'd3,
        S_ERR      = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [OP_W-1:0]    ar_q, ar_d;
    logic [OP_W-1:0]    br_q, br_d;
    logic               st_div_q, st_div_d;
    logic               st_dec_q, st_dec_d;
    logic               res_we_q, res_we_d;
    logic               busy_q, busy_d;
    logic               err_div0_q, err_div0_d;
    logic               err_tmo_q, err_tmo_d;
    logic [CNT_W-1:0]   calc_cnt_q, calc_cnt_d;

    logic               trig_c;
    logic               capture_c;
    logic               div0_c;
    logic               tmo_c;
    logic               done_c;

`ifdef CALC_SEQ_CHANGE_DET_EN
    logic               inv_q, inv_d;

    // Start only on new operands, or when the last result cannot be trusted.
    assign trig_c = (A != ar_q) || (B != br_q) || inv_q;

    always_comb begin
        inv_d = inv_q;
        if (done_c) begin
            inv_d = 1'b0;
        end
        if (div0_c || tmo_c) begin
            inv_d = 1'b1;
        end
    end
`else
    logic               unused_ops_c;

    assign trig_c       = 1'b1;
    assign unused_ops_c = ^{ar_q, br_q};
`endif

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            ar_q       <= '0;
            br_q       <= '0;
            st_div_q   <= 1'b0;
            st_dec_q   <= 1'b0;
            res_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            err_div0_q <= 1'b0;
            err_tmo_q  <= 1'b0;
            calc_cnt_q <= '0;
`ifdef CALC_SEQ_CHANGE_DET_EN
            inv_q      <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            ar_q       <= ar_d;
            br_q       <= br_d;
            st_div_q   <= st_div_d;
            st_dec_q   <= st_dec_d;
            res_we_q   <= res_we_d;
            busy_q     <= busy_d;
            err_div0_q <= err_div0_d;
            err_tmo_q  <= err_tmo_d;
            calc_cnt_q <= calc_cnt_d;
`ifdef CALC_SEQ_CHANGE_DET_EN
            inv_q      <= inv_d;
`endif
        end
    end

    // Next state; ok in the start-pulse cycle is ignored, ok beats a coincident timeout.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        capture_c = 1'b0;
        div0_c    = 1'b0;
        tmo_c     = 1'b0;
        done_c    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ce && trig_c) begin
                    capture_c = 1'b1;
                    tmr_d     = '0;
                    if (B == '0) begin
                        state_d = S_ERR;
                        div0_c  = 1'b1;
                    end else begin
                        state_d = S_MUL_WAIT;
                    end
                end
            end
            S_MUL_WAIT: begin
                if (tmr_q == MUL_LAST) begin
                    state_d = S_DIV_RUN;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_DIV_RUN: begin
                if (ok_div && !st_div_q) begin
                    state_d = S_DEC_RUN;
                    tmr_d   = '0;
                end else if (tmr_q == TMO_LAST) begin
                    state_d = S_ERR;
                    tmo_c   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_DEC_RUN: begin
                if (ok_dec && !st_dec_q) begin
                    state_d = S_IDLE;
                    done_c  = 1'b1;
                end else if (tmr_q == TMO_LAST) begin
                    state_d = S_ERR;
                    tmo_c   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_ERR: begin
                if (ce) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values, derived from the transition being taken.
    always_comb begin
        st_div_d   = (state_d == S_DIV_RUN) && (state_q != S_DIV_RUN);
        st_dec_d   = (state_d == S_DEC_RUN) && (state_q != S_DEC_RUN);
        res_we_d   = done_c;
        busy_d     = (state_d == S_MUL_WAIT) || (state_d == S_DIV_RUN) || (state_d == S_DEC_RUN);
        ar_d       = capture_c ? A : ar_q;
        br_d       = capture_c ? B : br_q;
        calc_cnt_d = done_c ? calc_cnt_q + CNT_W'(1) : calc_cnt_q;
        err_div0_d = err_div0_q;
        err_tmo_d  = err_tmo_q;
        if (done_c) begin
            err_div0_d = 1'b0;
            err_tmo_d  = 1'b0;
        end
        if (div0_c) begin
            err_div0_d = 1'b1;
        end
        if (tmo_c) begin
            err_tmo_d = 1'b1;
        end
    end

    assign st_div   = st_div_q;
    assign st_dec   = st_dec_q;
    assign res_we   = res_we_q;
    assign busy     = busy_q;
    assign err_div0 = err_div0_q;
    assign err_tmo  = err_tmo_q;
    assign calc_cnt = calc_cnt_q;

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: timestamp-based behavioural model checked every cycle, plus directed literal checks.
module tb_calc_seq;

    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned TMO     = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        ok_div = 1'b0;
    logic        ok_dec = 1'b0;
    logic        st_div, st_dec, res_we, busy, err_div0, err_tmo;
    logic [7:0]  calc_cnt;

    calc_seq #(.MUL_LAT(MUL_LAT), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .A(A), .B(B),
        .ok_div(ok_div), .ok_dec(ok_dec),
        .st_div(st_div), .st_dec(st_dec), .res_we(res_we), .busy(busy),
        .err_div0(err_div0), .err_tmo(err_tmo), .calc_cnt(calc_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int rc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: tracks the running calculation by cycle deadlines.
    typedef enum int {M_IDLE, M_MUL, M_DIV, M_DEC, M_ERR} mode_e;
    mode_e       mode = M_IDLE;
    int          cyc = 0;
    int          div_at, dec_at, tmo_at;
    logic [15:0] m_ar, m_br;
    bit          m_inv, m_valid = 0;
    bit          e_st_div, e_st_dec, e_res_we, e_busy, e_div0, e_tmo;
    int          e_cnt;

    always @(posedge clk) begin
        int  c;
        bit  trig;
        c = cyc;
        e_st_div = 0;
        e_st_dec = 0;
        e_res_we = 0;
`ifdef CALC_SEQ_CHANGE_DET_EN
        trig = (A != m_ar) || (B != m_br) || m_inv;
`else
        trig = 1;
`endif
        if (!rst_n) begin
            mode = M_IDLE; e_cnt = 0; e_div0 = 0; e_tmo = 0;
            m_ar = 0; m_br = 0; m_inv = 1; m_valid = 1;
        end else begin
            case (mode)
                M_IDLE: if (ce && trig) begin
                    m_ar = A; m_br = B;
                    if (B == 0) begin
                        mode = M_ERR; e_div0 = 1; m_inv = 1;
                    end else begin
                        mode = M_MUL; div_at = c + 1 + MUL_LAT;
                    end
                end
                M_MUL: if (c + 1 == div_at) begin
                    mode = M_DIV; e_st_div = 1; tmo_at = div_at + TMO;
                end
                M_DIV: if (ok_div && c > div_at) begin
                    mode = M_DEC; e_st_dec = 1; dec_at = c + 1; tmo_at = c + 1 + TMO;
                end else if (c + 1 == tmo_at) begin
                    mode = M_ERR; e_tmo = 1; m_inv = 1;
                end
                M_DEC: if (ok_dec && c > dec_at) begin
                    mode = M_IDLE; e_res_we = 1; e_cnt = (e_cnt + 1) % 256;
                    e_div0 = 0; e_tmo = 0; m_inv = 0;
                end else if (c + 1 == tmo_at) begin
                    mode = M_ERR; e_tmo = 1; m_inv = 1;
                end
                M_ERR: if (ce) mode = M_IDLE;
                default: mode = M_IDLE;
            endcase
        end
        e_busy = (mode == M_MUL) || (mode == M_DIV) || (mode == M_DEC);
        cyc = c + 1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_st_div", st_div, e_st_div);
            chk("m_st_dec", st_dec, e_st_dec);
            chk("m_res_we", res_we, e_res_we);
            chk("m_busy", busy, e_busy);
            chk("m_err_div0", err_div0, e_div0);
            chk("m_err_tmo", err_tmo, e_tmo);
            chk("m_calc_cnt", calc_cnt, e_cnt);
        end
    end

    task automatic step();
        @(negedge clk);
        rc++;
    endtask

    task automatic goto(input int n);
        while (rc < n) step();
    endtask

    // ce sampled at the end of relative cycle 0; returns observing cycle 1.
    task automatic start(input logic [15:0] a, input logic [15:0] b);
        A = a; B = b; ce = 1'b1; rc = 0;
        step();
        ce = 1'b0;
    endtask

    task automatic ok_div_at(input int n);
        goto(n); ok_div = 1'b1; step(); ok_div = 1'b0;
    endtask

    task automatic ok_dec_at(input int n);
        goto(n); ok_dec = 1'b1; step(); ok_dec = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; step(); rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_st_div", st_div, 0);
        chk("rst_res_we", res_we, 0);
        chk("rst_errs", {err_div0, err_tmo}, 0);
        chk("rst_cnt", calc_cnt, 0);
        rst_n = 1'b1;
        step();

        // Nominal run; an ok_div during the st_div cycle must be ignored.
        start(100, 7);
        chk("nom_busy_c1", busy, 1);
        goto(2);  chk("nom_st_div_c2", st_div, 0);
        goto(3);  chk("nom_st_div_c3", st_div, 1);
        ok_div = 1'b1; step(); ok_div = 1'b0;
        chk("nom_early_ok", st_dec, 0);
        ok_div_at(10);
        chk("nom_st_dec_c11", st_dec, 1);
        goto(20); chk("nom_busy_c20", busy, 1);
        ok_dec_at(20);
        chk("nom_res_we_c21", res_we, 1);
        chk("nom_cnt", calc_cnt, 1);
        chk("nom_busy_c21", busy, 0);
        step();   chk("nom_res_we_c22", res_we, 0);

        // Divide by zero, ERR exit on ce, then a good run clears the flag.
        start(100, 0);
        chk("d0_flag", err_div0, 1);
        chk("d0_busy", busy, 0);
        goto(5);  chk("d0_no_st_div", st_div, 0);
        start(100, 0);
        chk("d0_exit_busy", busy, 0);
        chk("d0_sticky", err_div0, 1);
        goto(3);  chk("d0_idle", busy, 0);
        start(100, 5);
        ok_div_at(10);
        ok_dec_at(20);
        chk("d0_res_we", res_we, 1);
        chk("d0_cleared", err_div0, 0);
        chk("d0_cnt", calc_cnt, 2);

        // Divider timeout: st_div at cycle 3, error 255 cycles later.
        start(50, 3);
        goto(257);
        chk("tmo_pre_flag", err_tmo, 0);
        chk("tmo_pre_busy", busy, 1);
        step();
        chk("tmo_flag", err_tmo, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_no_st_dec", st_dec, 0);
        start(50, 3);
        chk("tmo_exit", busy, 0);

        // ok_div in the final waiting cycle wins over the timeout.
        start(50, 3);
        ok_div_at(257);
        chk("okwin_st_dec", st_dec, 1);
        chk("okwin_busy", busy, 1);
        ok_dec_at(260);
        chk("okwin_res_we", res_we, 1);
        chk("okwin_tmo_clr", err_tmo, 0);
        chk("okwin_cnt", calc_cnt, 3);

        // Converter timeout: st_dec at cycle 5, error at cycle 260.
        start(60, 3);
        ok_div_at(4);
        chk("dtmo_st_dec", st_dec, 1);
        goto(260);
        chk("dtmo_flag", err_tmo, 1);
        start(60, 3);

        // Reset during DIV_RUN; a late ok_div must not produce st_dec.
        start(10, 2);
        goto(5);  chk("rmid_busy", busy, 1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("rmid_busy0", busy, 0);
        chk("rmid_flags", {err_div0, err_tmo}, 0);
        chk("rmid_cnt", calc_cnt, 0);
        ok_div = 1'b1; step(); ok_div = 1'b0;
        chk("rmid_no_st_dec", st_dec, 0);
        step();   chk("rmid_no_st_dec2", st_dec, 0);

`ifdef CALC_SEQ_CHANGE_DET_EN
        start(10, 2); ok_div_at(5); ok_dec_at(8);
        for (int i = 0; i < 3; i++) begin
            start(10, 2);
            chk("cd_no_start", busy, 0);
            goto(4);
        end
        start(101, 2);
        chk("cd_new_start", busy, 1);
        ok_div_at(5); ok_dec_at(8);
        chk("cd_cnt", calc_cnt, 2);
`else
        for (int i = 0; i < 3; i++) begin
            start(10, 2); ok_div_at(5); ok_dec_at(8);
            chk("nocd_res_we", res_we, 1);
        end
        chk("nocd_cnt", calc_cnt, 3);
`endif

        // calc_cnt wrap 255 -> 0.
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            start(16'(i), 3); ok_div_at(4); ok_dec_at(6);
            if (i == 255) chk("wrap_255", calc_cnt, 255);
        end
        chk("wrap_0", calc_cnt, 0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
